// File: rtl/disp_scan_ctrl.sv
// Time-multiplexed 7-seg digit scanner: frame snapshot, ghost blanking, LZ suppression, blinking.
// All outputs registered (one cycle after inputs are sampled); no backpressure, en=0 darkens next cycle.
module disp_scan_ctrl #(
  parameter int DIGITS       = 4,
  parameter int TICK_DIV     = 50000,
  parameter int BLANK_CYC    = 500,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                        ck,
  input  logic                        reset,
  input  logic                        en,
  input  logic [4*DIGITS-1:0]         digit_data,
  input  logic                        lz_en,
  input  logic [DIGITS-1:0]           blink_mask,
  output logic [3:0]                  seg_data,
  output logic [DIGITS-1:0]           ctrl_data,
  output logic [$clog2(DIGITS)-1:0]   digit_idx,
  output logic                        frame_start
);

  localparam int IW = $clog2(DIGITS);
  localparam int CW = $clog2(TICK_DIV);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BLANK = 2'd1;
  localparam logic [1:0] ST_SHOW  = 2'd2;

  localparam logic [CW-1:0] CNT_LAST  = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYC);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);
  localparam logic [FW-1:0] FRM_LAST  = FW'(BLINK_FRAMES - 1);

  logic [1:0]          state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [4*DIGITS-1:0] snap_q, snap_d;
  logic [FW-1:0]       frm_q, frm_d;
  logic                phase_q, phase_d;
  logic [3:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   ctrl_q, ctrl_d;
  logic                fs_q, fs_d;

  logic [DIGITS-1:0]   lz_sup;
  logic                zero_above;
  logic                sup;
  logic [3:0]          nib;

  // Slot/frame sequencing; the snapshot is only refreshed when a frame begins.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    snap_d  = snap_q;
    frm_d   = frm_q;
    phase_d = phase_q;
    fs_d    = 1'b0;
    if (!en) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      idx_d   = '0;
      snap_d  = '0;
    end else begin
      if (state_q == ST_IDLE) begin
        cnt_d  = '0;
        idx_d  = '0;
        snap_d = digit_data;
        fs_d   = 1'b1;
      end else if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        if (idx_q == IDX_LAST) begin
          idx_d  = '0;
          snap_d = digit_data;
          fs_d   = 1'b1;
          if (frm_q == FRM_LAST) begin
            frm_d   = '0;
            phase_d = ~phase_q;
          end else begin
            frm_d = frm_q + 1'b1;
          end
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      state_d = (cnt_d < CNT_BLANK) ? ST_BLANK : ST_SHOW;
    end
  end

  // lz_sup[i]: nibbles i..DIGITS-1 of the upcoming snapshot are all zero (digit 0 exempt).
  always_comb begin
    lz_sup     = '0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above & (snap_d[4*i +: 4] == 4'h0);
      lz_sup[i]  = zero_above;
    end
  end

  // Outputs are computed from next-state values so the registered outputs track the slot exactly.
  always_comb begin
    seg_d  = 4'h0;
    ctrl_d = '0;
    sup    = (lz_en & lz_sup[idx_d]) | (blink_mask[idx_d] & phase_d);
    nib    = snap_d[{idx_d, 2'b00} +: 4];
    if (state_d != ST_IDLE && !sup) begin
      seg_d = nib;
      if (state_d == ST_SHOW) begin
        ctrl_d = DIGITS'(1) << idx_d;
      end
    end
  end

  always_ff @(posedge ck or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      snap_q  <= '0;
      frm_q   <= '0;
      phase_q <= 1'b0;
      seg_q   <= 4'h0;
      ctrl_q  <= '0;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      frm_q   <= frm_d;
      phase_q <= phase_d;
      seg_q   <= seg_d;
      ctrl_q  <= ctrl_d;
      fs_q    <= fs_d;
    end
  end

  assign seg_data    = seg_q;
  assign ctrl_data   = ctrl_q;
  assign digit_idx   = idx_q;
  assign frame_start = fs_q;

endmodule
